fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the two-phase control unit.
- Consumes the control unit's PC-write, instruction-read and branch strobes.
- Owns the PC and the instruction register (IR). Issues requests to instruction memory over a req/ack handshake with variable latency.
- Presents decoded opcode/func3/register fields to the control unit and datapath. Computes the branch target internally from the B-type immediate held in IR.

Parameters:
- XLEN, 32, data/address width of PC and IR
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  synchronous reset, active-low
- pc_write  in  1  PC update strobe from control
- instruction_read  in  1  fetch strobe from control
- branch  in  1  branch-taken qualifier from control; meaningful only with pc_write
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  XLEN  fetch address
- imem_rdata  in  32  instruction word, valid with imem_ack
- imem_ack  in  1  one-cycle response strobe
- instr  out  32  IR contents
- opcode  out  7  instr[6:0]
- func3  out  3  instr[14:12]
- rd  out  5  instr[11:7]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- pc  out  XLEN  next fetch address
- ir_pc  out  XLEN  address of the instruction currently in IR
- instr_valid  out  1  IR holds a fetched instruction
- fetch_stall  out  1  fetch outstanding or PC update pending
- misalign_err  out  1  sticky misaligned branch target (feature only; else tied 0)

Behaviour:

Reset (rst_n low at a clk edge):
- pc=RESET_PC, ir_pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0.
- imem_req=0, fetch_stall=0, misalign_err=0, state=IDLE, pending flag cleared.
- Reset mid-fetch abandons the request. An imem_ack arriving in the first cycle after reset is ignored.

FSM states: IDLE, WAIT.
- IDLE, instruction_read=1:
  - Register imem_req=1 and imem_addr=pc on the same edge.
  - Go to WAIT. fetch_stall=1 from the next cycle.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, ir_pc<=imem_addr, instr_valid<=1, imem_req<=0, go to IDLE.
  - An ack in the same cycle req first rises is impossible by construction, since req is registered.
- instruction_read while in WAIT is ignored; there is no queueing.

PC update (the cycle pc_write=1):
- branch=0: pc <= pc + PC_STEP.
- branch=1: pc <= ir_pc + sext(immB). immB = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}, 13 bits, sign-extended to XLEN.
- Arithmetic is modulo 2^XLEN; wrap-around at 2^XLEN-4 → 0 is silent.
- pc_write and instruction_read in the same IDLE cycle: the fetch uses the old pc; pc updates on that same edge. This matches the control unit's fetch phase, which asserts both together.
- pc_write while in WAIT: the update is captured in a pending register (target value). It is applied on the ack edge, and fetch_stall stays 1 until then. A second pc_write while pending overwrites the pending value.

Outputs:
- instr_valid stays 1 until reset. The IR is only overwritten by a new ack.
- fetch_stall = (state==WAIT) | pending.
- Decoded fields are combinational slices of IR, so they have zero latency after IR updates.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined: a branch target with bits[1:0]≠0 does not update pc (pc keeps its old value, no +4) and sets misalign_err=1, which stays set until reset.
- Undefined: target bits[1:0] are forced to 2'b00 and pc is updated; misalign_err is tied 0.

Decomposition:
- Package rv_fetch_pkg holds:
  - opcode localparams (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011)
  - NOP_INSTR constant
  - fetch_state_t enum {IDLE, WAIT}
- One sub-module: branch_imm_gen, a combinational immB extraction plus sign extension from a 32-bit instruction. It is reusable by the datapath.

Test Plan:
- Reset with RESET_PC=32'h100, then instruction_read pulse, ack after 3 cycles with rdata=32'h00500093 → imem_addr=32'h100, instr=32'h00500093, opcode=7'h13, rd=1, ir_pc=32'h100, fetch_stall high for 3 cycles.
- Fetch with pc_write=1 and branch=0 in the same cycle at pc=32'h100 → imem_addr=32'h100, pc=32'h104.
- IR=32'hFE000EE3 (beq, offset −4) at ir_pc=32'h108, pc_write=1 and branch=1 → pc=32'h104.
- pc_write with branch=0 issued during WAIT at pc=32'h104, ack 2 cycles later → pc stays 32'h104 until the ack edge, then becomes 32'h108; fetch_stall drops the cycle after the ack.
- pc=32'hFFFF_FFFC with pc_write=1 and branch=0 → pc=32'h0.
- With FETCH_MISALIGN_CHK_EN defined, a branch target of ir_pc+2 → pc unchanged and misalign_err=1 until rst_n is low at a clk edge. Without the macro → pc=target&~3 and misalign_err=0.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: opcodes, NOP encoding, fetch FSM states.
// Optional misaligned-target checking is enabled by defining FETCH_MISALIGN_CHK_EN.
package rv_fetch_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/branch_imm_gen.sv
// B-type immediate extraction with sign extension to XLEN.
// Purely combinational, so the datapath can reuse it.
module branch_imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    logic [12:0] w_imm13;

    assign w_imm13 = {i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};

    assign o_imm = {{(XLEN-13){w_imm13[12]}}, w_imm13};

endmodule

// File: rtl/fetch_unit.sv
// PC and IR owner with a req/ack instruction fetch and pending PC update.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned branch targets.
module fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            instruction_read,
    input  logic            branch,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ir_pc,
    output logic            instr_valid,
    output logic            fetch_stall,
    output logic            misalign_err
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir_pc;
    logic [31:0]     r_instr;
    logic            r_valid;
    logic            r_req;
    logic [XLEN-1:0] r_addr;
    logic            r_pend;
    logic [XLEN-1:0] r_pend_pc;

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_seq;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_next;
    logic            w_upd;

    branch_imm_gen #(
        .XLEN (XLEN)
    ) u_imm (
        .i_instr (r_instr),
        .o_imm   (w_imm)
    );

    assign w_seq = r_pc + XLEN'(PC_STEP);
    assign w_tgt = r_ir_pc + w_imm;

`ifdef FETCH_MISALIGN_CHK_EN
    logic w_mis;
    logic r_err;

    assign w_mis  = branch & (w_tgt[1:0] != 2'b00);
    assign w_next = branch ? w_tgt : w_seq;
    assign w_upd  = pc_write & ~w_mis;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (pc_write && w_mis)
            r_err <= 1'b1;
    end

    assign misalign_err = r_err;
`else
    assign w_next = branch ? (w_tgt & ~XLEN'(3)) : w_seq;
    assign w_upd  = pc_write;

    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= XLEN'(RESET_PC);
            r_ir_pc   <= XLEN'(RESET_PC);
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_addr    <= XLEN'(RESET_PC);
            r_pend    <= 1'b0;
            r_pend_pc <= XLEN'(RESET_PC);
        end else begin
            unique case (r_state)
                IDLE: begin
                    // Fetch samples the old pc even when pc updates this edge
                    if (instruction_read) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                        r_state <= WAIT;
                    end
                    if (w_upd)
                        r_pc <= w_next;
                end
                WAIT: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_ir_pc <= r_addr;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                        r_pend  <= 1'b0;
                        if (w_upd)
                            r_pc <= w_next;
                        else if (r_pend)
                            r_pc <= r_pend_pc;
                    end else if (w_upd) begin
                        r_pend    <= 1'b1;
                        r_pend_pc <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign opcode      = r_instr[6:0];
    assign rd          = r_instr[11:7];
    assign func3       = r_instr[14:12];
    assign rs1         = r_instr[19:15];
    assign rs2         = r_instr[24:20];
    assign pc          = r_pc;
    assign ir_pc       = r_ir_pc;
    assign instr_valid = r_valid;
    assign fetch_stall = (r_state == WAIT) | r_pend;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latency, PC updates, pending
// updates during WAIT, branch targets, wrap-around and misalignment.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, instruction_read, branch;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr, pc, ir_pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd, rs1, rs2;
    logic        instr_valid, fetch_stall, misalign_err;

    logic        w_pc_write;
    logic        w_req, w_valid, w_stall, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_ir_pc;
    logic [6:0]  w_opcode;
    logic [2:0]  w_func3;
    logic [4:0]  w_rd, w_rs1, w_rs2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h100), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_write(pc_write), .instruction_read(instruction_read),
        .branch(branch),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .instr(instr), .opcode(opcode), .func3(func3),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .pc(pc), .ir_pc(ir_pc), .instr_valid(instr_valid),
        .fetch_stall(fetch_stall), .misalign_err(misalign_err)
    );

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .pc_write(w_pc_write), .instruction_read(1'b0),
        .branch(1'b0),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(32'h0), .imem_ack(1'b0),
        .instr(w_instr), .opcode(w_opcode), .func3(w_func3),
        .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2),
        .pc(w_pc), .ir_pc(w_ir_pc), .instr_valid(w_valid),
        .fetch_stall(w_stall), .misalign_err(w_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pc_write = 1'b0;
        instruction_read = 1'b0;
        branch = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        w_pc_write = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_ir_pc", ir_pc, 32'h100);
        chk("rst_instr", instr, 32'h13);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_stall", {31'b0, fetch_stall}, 32'd0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

        // stray ack right after reset
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("early_ack_valid", {31'b0, instr_valid}, 32'd0);
        chk("early_ack_instr", instr, 32'h13);

        // fetch at 0x100 with 3-cycle latency
        instruction_read = 1'b1;
        tick();
        instruction_read = 1'b0;
        chk("f1_req", {31'b0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h100);
        chk("f1_stall0", {31'b0, fetch_stall}, 32'd1);
        tick();
        chk("f1_stall1", {31'b0, fetch_stall}, 32'd1);
        tick();
        chk("f1_stall2", {31'b0, fetch_stall}, 32'd1);
        chk("f1_addr_hold", imem_addr, 32'h100);
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_ack = 1'b0;
        chk("f1_instr", instr, 32'h0050_0093);
        chk("f1_opcode", {25'b0, opcode}, 32'h13);
        chk("f1_rd", {27'b0, rd}, 32'd1);
        chk("f1_func3", {29'b0, func3}, 32'd0);
        chk("f1_rs1", {27'b0, rs1}, 32'd0);
        chk("f1_ir_pc", ir_pc, 32'h100);
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_stall_end", {31'b0, fetch_stall}, 32'd0);
        chk("f1_req_end", {31'b0, imem_req}, 32'd0);
        chk("f1_pc", pc, 32'h100);

        // fetch and sequential pc_write on the same edge
        instruction_read = 1'b1;
        pc_write = 1'b1;
        tick();
        instruction_read = 1'b0;
        pc_write = 1'b0;
        chk("f2_addr", imem_addr, 32'h100);
        chk("f2_pc", pc, 32'h104);
        imem_ack = 1'b1;
        imem_rdata = 32'h0020_81B3;
        tick();
        imem_ack = 1'b0;
        chk("f2_opcode", {25'b0, opcode}, 32'h33);
        chk("f2_rd", {27'b0, rd}, 32'd3);
        chk("f2_rs1", {27'b0, rs1}, 32'd1);
        chk("f2_rs2", {27'b0, rs2}, 32'd2);
        chk("f2_pc_hold", pc, 32'h104);

        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        chk("seq_pc", pc, 32'h108);

        // fetch beq -4 at 0x108 and take it
        instruction_read = 1'b1;
        tick();
        instruction_read = 1'b0;
        chk("f3_addr", imem_addr, 32'h108);
        imem_ack = 1'b1;
        imem_rdata = 32'hFE00_0EE3;
        tick();
        imem_ack = 1'b0;
        chk("f3_ir_pc", ir_pc, 32'h108);
        chk("f3_opcode", {25'b0, opcode}, 32'h63);
        pc_write = 1'b1;
        branch = 1'b1;
        tick();
        pc_write = 1'b0;
        branch = 1'b0;
        chk("br_back_pc", pc, 32'h104);

        // pc_write during WAIT is held pending until ack
        instruction_read = 1'b1;
        tick();
        instruction_read = 1'b0;
        chk("f4_addr", imem_addr, 32'h104);
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
        chk("pend_pc0", pc, 32'h104);
        chk("pend_stall0", {31'b0, fetch_stall}, 32'd1);
        tick();
        chk("pend_pc1", pc, 32'h104);
        chk("pend_stall1", {31'b0, fetch_stall}, 32'd1);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0163;
        tick();
        imem_ack = 1'b0;
        chk("pend_pc_ack", pc, 32'h108);
        chk("pend_stall_ack", {31'b0, fetch_stall}, 32'd0);
        chk("f4_ir_pc", ir_pc, 32'h104);

        // branch +2 from 0x104 -> target 0x106
        pc_write = 1'b1;
        branch = 1'b1;
        tick();
        branch = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_pc", pc, 32'h108);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        tick();
        pc_write = 1'b0;
        chk("mis_seq_pc", pc, 32'h10C);
        chk("mis_err_sticky", {31'b0, misalign_err}, 32'd1);
`else
        chk("mis_pc", pc, 32'h104);
        chk("mis_err", {31'b0, misalign_err}, 32'd0);
        tick();
        pc_write = 1'b0;
        chk("mis_seq_pc", pc, 32'h108);
        chk("mis_err_sticky", {31'b0, misalign_err}, 32'd0);
`endif

        // wrap-around from 0xFFFF_FFFC
        w_pc_write = 1'b1;
        tick();
        w_pc_write = 1'b0;
        chk("wrap_pc", w_pc, 32'h0);

        // reset in the middle of a fetch
        instruction_read = 1'b1;
        tick();
        instruction_read = 1'b0;
        chk("mid_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_stall", {31'b0, fetch_stall}, 32'd0);
        chk("mid_rst_err", {31'b0, misalign_err}, 32'd0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_pc", pc, 32'h100);
        chk("mid_rst_instr", instr, 32'h13);
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("mid_late_ack", {31'b0, instr_valid}, 32'd0);
        chk("mid_late_instr", instr, 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
